// File: rtl/hsv_pkg.sv
// hsv_pkg: shared HSV field selects, bound reset fills and channel slice helpers.
package hsv_pkg;
  localparam int NUM_FIELDS = 6;
  localparam int FLD_H_LO = 0;
  localparam int FLD_H_HI = 1;
  localparam int FLD_S_LO = 2;
  localparam int FLD_S_HI = 3;
  localparam int FLD_V_LO = 4;
  localparam int FLD_V_HI = 5;
  localparam logic BOUND_LO_FILL = 1'b1;
  localparam logic BOUND_HI_FILL = 1'b0;
  function automatic logic bound_fill(int f);
    return (f % 2 == 0) ? BOUND_LO_FILL : BOUND_HI_FILL;
  endfunction
  function automatic int h_lsb(int w);
    return 2 * w;
  endfunction
  function automatic int s_lsb(int w);
    return w;
  endfunction
  function automatic int v_lsb(int w);
    return 0 * w;
  endfunction
endpackage

// File: rtl/hsv_range_cmp.sv
// hsv_range_cmp: inclusive unsigned window test; lo > hi is empty unless wrap_en, then it wraps through 0.
module hsv_range_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic         wrap_en,
  output logic         match
);
  always_comb match = (lo <= hi) ? (x >= lo && x <= hi) : (wrap_en && (x >= lo || x <= hi));
endmodule

// File: rtl/hsv_class_threshold.sv
// hsv_class_threshold: multi-class HSV window classifier, 2-stage pipeline, frame-synchronous bounds.
// Optional per-frame hit counters are built when HSV_CLASS_COUNT_EN is defined.
module hsv_class_threshold
  import hsv_pkg::*;
#(
  parameter int NUM_CLASSES = 4,
  parameter int CHAN_W = 8,
  parameter int CNT_W = 20,
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [CLS_W-1:0]             cfg_class,
  input  logic [2:0]                   cfg_field,
  input  logic [CHAN_W-1:0]            cfg_data,
  input  logic                         frame_start,
  input  logic                         in_valid,
  input  logic [3*CHAN_W-1:0]          in_rgb,
  input  logic [3*CHAN_W-1:0]          in_hsv,
  output logic                         out_valid,
  output logic [3*CHAN_W-1:0]          out_rgb,
  output logic [NUM_CLASSES-1:0]       out_match,
  output logic                         out_hit,
  output logic [CLS_W-1:0]             out_class,
  output logic                         cnt_valid,
  output logic [NUM_CLASSES*CNT_W-1:0] cnt_out
);
  localparam int H_LSB = h_lsb(CHAN_W);
  localparam int S_LSB = s_lsb(CHAN_W);
  localparam int V_LSB = v_lsb(CHAN_W);
  logic [CHAN_W-1:0] shadow_q [NUM_CLASSES][NUM_FIELDS];
  logic [CHAN_W-1:0] active_q [NUM_CLASSES][NUM_FIELDS];
  logic cfg_ok;
  logic [NUM_CLASSES-1:0] match_d, s1_match_q, out_match_q;
  logic s1_valid_q, out_valid_q, out_hit_q;
  logic [3*CHAN_W-1:0] s1_rgb_q, out_rgb_q;
  logic [CLS_W-1:0] cls_d, out_class_q;
  assign cfg_ok = cfg_we && ({1'b0, cfg_class} < (CLS_W+1)'(NUM_CLASSES)) && (cfg_field < 3'(NUM_FIELDS));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int f = 0; f < NUM_FIELDS; f++) begin
          shadow_q[c][f] <= {CHAN_W{bound_fill(f)}};
          active_q[c][f] <= {CHAN_W{bound_fill(f)}};
        end
    end else begin
      if (frame_start) active_q <= shadow_q;
      if (cfg_ok) shadow_q[cfg_class][cfg_field] <= cfg_data;
    end
  end
  // A pixel coincident with frame_start already sees the bounds being promoted this cycle.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    logic [CHAN_W-1:0] bnd [NUM_FIELDS];
    logic [2:0] hit;
    always_comb
      for (int f = 0; f < NUM_FIELDS; f++) bnd[f] = frame_start ? shadow_q[c][f] : active_q[c][f];
    hsv_range_cmp #(.W(CHAN_W)) u_h (
      .x(in_hsv[H_LSB +: CHAN_W]), .lo(bnd[FLD_H_LO]), .hi(bnd[FLD_H_HI]), .wrap_en(1'b1), .match(hit[0])
    );
    hsv_range_cmp #(.W(CHAN_W)) u_s (
      .x(in_hsv[S_LSB +: CHAN_W]), .lo(bnd[FLD_S_LO]), .hi(bnd[FLD_S_HI]), .wrap_en(1'b0), .match(hit[1])
    );
    hsv_range_cmp #(.W(CHAN_W)) u_v (
      .x(in_hsv[V_LSB +: CHAN_W]), .lo(bnd[FLD_V_LO]), .hi(bnd[FLD_V_HI]), .wrap_en(1'b0), .match(hit[2])
    );
    assign match_d[c] = &hit;
  end
  always_comb begin
    cls_d = '0;
    for (int k = NUM_CLASSES - 1; k >= 0; k--) cls_d = s1_match_q[k] ? CLS_W'(k) : cls_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_rgb_q    <= '0;
      s1_match_q  <= '0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_match_q <= '0;
      out_hit_q   <= 1'b0;
      out_class_q <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      s1_rgb_q    <= in_rgb;
      s1_match_q  <= match_d;
      out_valid_q <= s1_valid_q;
      out_rgb_q   <= s1_rgb_q;
      out_match_q <= s1_valid_q ? s1_match_q : '0;
      out_hit_q   <= s1_valid_q && |s1_match_q;
      out_class_q <= s1_valid_q ? cls_d : '0;
    end
  end
  assign out_valid = out_valid_q;
  assign out_rgb   = out_rgb_q;
  assign out_match = out_match_q;
  assign out_hit   = out_hit_q;
  assign out_class = out_class_q;
`ifdef HSV_CLASS_COUNT_EN
  logic [1:0] fs_q;
  logic cnt_valid_q;
  logic [NUM_CLASSES*CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] acc_q [NUM_CLASSES];
  logic [CNT_W-1:0] acc_inc [NUM_CLASSES];
  logic [CNT_W-1:0] acc_d [NUM_CLASSES];
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      acc_inc[k] = (out_valid_q && out_match_q[k] && acc_q[k] != '1) ? acc_q[k] + CNT_W'(1) : acc_q[k];
      acc_d[k]   = fs_q[1] ? CNT_W'(out_valid_q && out_match_q[k]) : acc_inc[k];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_q        <= '0;
      cnt_valid_q <= 1'b0;
      cnt_q       <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= '0;
    end else begin
      fs_q        <= {fs_q[0], frame_start};
      cnt_valid_q <= fs_q[1];
      for (int k = 0; k < NUM_CLASSES; k++) begin
        acc_q[k] <= acc_d[k];
        if (fs_q[1]) cnt_q[k*CNT_W +: CNT_W] <= acc_inc[k];
      end
    end
  end
  assign cnt_valid = cnt_valid_q;
  assign cnt_out   = cnt_q;
`else
  assign cnt_valid = 1'b0;
  assign cnt_out   = '0;
`endif
endmodule

// File: tb/tb_hsv_class_threshold.sv
// tb_hsv_class_threshold: directed and randomized checks against a per-pixel behavioural model.
module tb_hsv_class_threshold;
`ifdef HSV_CLASS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int NC = 4;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_class = '0;
  logic [2:0] cfg_field = '0;
  logic [7:0] cfg_data = '0;
  logic frame_start = 1'b0;
  logic in_valid = 1'b0;
  logic [23:0] in_rgb = '0;
  logic [23:0] in_hsv = '0;
  logic out_valid, out_hit, cnt_valid;
  logic [23:0] out_rgb;
  logic [NC-1:0] out_match;
  logic [1:0] out_class;
  logic [NC*CW-1:0] cnt_out;
  int total = 0;
  int bad = 0;
  hsv_class_threshold #(.NUM_CLASSES(NC), .CHAN_W(8), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_field(cfg_field),
    .cfg_data(cfg_data), .frame_start(frame_start), .in_valid(in_valid), .in_rgb(in_rgb),
    .in_hsv(in_hsv), .out_valid(out_valid), .out_rgb(out_rgb), .out_match(out_match),
    .out_hit(out_hit), .out_class(out_class), .cnt_valid(cnt_valid), .cnt_out(cnt_out)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic v;
    logic fs;
    logic [23:0] rgb;
    logic [NC-1:0] m;
  } rec_t;
  int sh [NC][6];
  int act [NC][6];
  int acc [NC];
  rec_t q[$];
  rec_t cur, prev, nrec;
  logic [NC*CW-1:0] ecnt;
  logic ecv;
  bit started = 1'b0;

  function automatic bit in_win(int x, int lo, int hi, bit wrap);
    if (lo <= hi) return x >= lo && x <= hi;
    return wrap && (x >= lo || x <= hi);
  endfunction

  function automatic logic [NC-1:0] model_match(logic [23:0] hsv, bit use_sh);
    logic [NC-1:0] r = '0;
    for (int c = 0; c < NC; c++) begin
      int b[6];
      for (int f = 0; f < 6; f++) b[f] = use_sh ? sh[c][f] : act[c][f];
      r[c] = in_win(int'(hsv[23:16]), b[0], b[1], 1'b1) && in_win(int'(hsv[15:8]), b[2], b[3], 1'b0)
          && in_win(int'(hsv[7:0]), b[4], b[5], 1'b0);
    end
    return r;
  endfunction

  function automatic int lowest(logic [NC-1:0] m);
    int r = 0;
    for (int k = NC - 1; k >= 0; k--) if (m[k]) r = k;
    return r;
  endfunction

  function automatic int sat(int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NC; c++)
        for (int f = 0; f < 6; f++) begin
          sh[c][f] = (f % 2 == 0) ? 255 : 0;
          act[c][f] = sh[c][f];
        end
      for (int k = 0; k < NC; k++) acc[k] = 0;
      q.delete();
      q.push_back('0);
      cur = '0;
      ecnt = '0;
      ecv = 1'b0;
      started = 1'b1;
    end else begin
      prev = cur;
      if (CNT_EN) begin
        ecv = prev.fs;
        for (int k = 0; k < NC; k++) begin
          int h = (prev.v && prev.m[k]) ? 1 : 0;
          if (prev.fs) begin
            ecnt[k*CW +: CW] = CW'(sat(acc[k] + h));
            acc[k] = h;
          end else acc[k] = sat(acc[k] + h);
        end
      end
      nrec.v = in_valid;
      nrec.fs = frame_start;
      nrec.rgb = in_rgb;
      nrec.m = in_valid ? model_match(in_hsv, frame_start) : '0;
      q.push_back(nrec);
      cur = q.pop_front();
      if (frame_start) act = sh;
      if (cfg_we && cfg_field < 6) sh[cfg_class][cfg_field] = int'(cfg_data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 64'(out_valid), 64'(cur.v));
      chk("out_rgb", 64'(out_rgb), 64'(cur.rgb));
      chk("out_match", 64'(out_match), 64'(cur.m));
      chk("out_hit", 64'(out_hit), 64'(|cur.m));
      chk("out_class", 64'(out_class), 64'(lowest(cur.m)));
      chk("cnt_valid", 64'(cnt_valid), 64'(ecv));
      chk("cnt_out", 64'(cnt_out), 64'(ecnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int c, input int f, input int d);
    cfg_we = 1'b1;
    cfg_class = 2'(c);
    cfg_field = 3'(f);
    cfg_data = 8'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic prog(input int c, input int hl, input int hh, input int sl, input int shi, input int vl, input int vh);
    cfg(c, 0, hl); cfg(c, 1, hh); cfg(c, 2, sl); cfg(c, 3, shi); cfg(c, 4, vl); cfg(c, 5, vh);
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic px(input int h, input int s, input int v);
    in_valid = 1'b1;
    in_hsv = {8'(h), 8'(s), 8'(v)};
    in_rgb = 24'($urandom);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic px_check(input string name, input int h, input int s, input int v,
                          input logic [NC-1:0] em, input int ec, input logic eh);
    px(h, s, v);
    tick();
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_match"}, 64'(out_match), 64'(em));
    chk({name, "_class"}, 64'(out_class), 64'(ec));
    chk({name, "_hit"}, 64'(out_hit), 64'(eh));
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_match", 64'(out_match), 64'(0));
    chk("rst_cnt", 64'(cnt_out), 64'(0));
    reset = 1'b0;
    tick();
    prog(0, 140, 180, 100, 255, 50, 255);
    fs();
    px_check("basic", 160, 200, 120, 4'b0001, 0, 1'b1);
    prog(1, 240, 15, 0, 255, 0, 255);
    fs();
    px_check("wrap250", 250, 50, 50, 4'b0010, 1, 1'b1);
    px_check("wrap10", 10, 50, 50, 4'b0010, 1, 1'b1);
    px_check("wrap100", 100, 50, 50, 4'b0000, 0, 1'b0);
    prog(2, 50, 70, 0, 255, 0, 255);
    cfg(0, 0, 40);
    fs();
    px_check("prio", 60, 128, 128, 4'b0101, 0, 1'b1);
    px_check("nomatch", 200, 10, 10, 4'b0000, 0, 1'b0);
    cfg(0, 1, 150);
    px_check("dbuf_old", 160, 200, 120, 4'b0001, 0, 1'b1);
    fs();
    px_check("dbuf_new", 160, 200, 120, 4'b0000, 0, 1'b0);
    cfg_we = 1'b1; cfg_class = 2'd0; cfg_field = 3'd1; cfg_data = 8'd180; frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    px_check("coinc_pre", 160, 200, 120, 4'b0000, 0, 1'b0);
    fs();
    px_check("coinc_post", 160, 200, 120, 4'b0001, 0, 1'b1);
    fs();
    for (int i = 0; i < 100; i++) begin
      bit hit = ((i * 37) / 100) != (((i + 1) * 37) / 100);
      repeat ($urandom_range(0, 2)) tick();
      if (hit) px(160, 200, 120);
      else px(100, 10, 10);
    end
    fs();
    tick();
    tick();
    @(negedge clk);
    chk("cnt37_valid", 64'(cnt_valid), 64'(CNT_EN ? 1 : 0));
    chk("cnt37", 64'(cnt_out[0 +: CW]), 64'(CNT_EN ? 37 : 0));
    repeat (70) px(160, 200, 120);
    fs();
    tick();
    tick();
    @(negedge clk);
    chk("cnt_sat", 64'(cnt_out[0 +: CW]), 64'(CNT_EN ? CMAX : 0));
    chk("cnt_sat_c1", 64'(cnt_out[CW +: CW]), 64'(0));
    in_valid = 1'b1;
    in_hsv = {8'd160, 8'd200, 8'd120};
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_cnt", 64'(cnt_out), 64'(0));
    reset = 1'b0;
    in_valid = 1'b0;
    fs();
    px_check("midrst_nomatch", 160, 200, 120, 4'b0000, 0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_class = 2'($urandom);
      cfg_field = 3'($urandom);
      cfg_data = ($urandom_range(0, 2) == 0) ? (cfg_field[0] ? 8'hff : 8'h00) : 8'($urandom);
      frame_start = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_hsv = 24'($urandom);
      in_rgb = 24'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    cfg_we = 1'b0;
    frame_start = 1'b0;
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
